// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame loader: sync byte, parser states, error codes.
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        ADDR_HI,
        ADDR_LO,
        PAYLOAD,
        CSUM
    } frame_state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/uart_word_packer.sv
// Packs payload bytes little-endian into 32-bit words and issues one registered
// write per completed word, advancing a wrapping word address.
module uart_word_packer
    import uart_frame_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              i_Clock,
    input  logic              i_Rst_L,
    input  logic              clear,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data
);

    logic [1:0]        lane;
    logic [23:0]       shift;
    logic [ADDR_W-1:0] addr;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            lane    <= 2'd0;
            shift   <= 24'd0;
            addr    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 32'd0;
        end else begin
            wr_en <= 1'b0;
            if (load_addr) begin
                addr <= start_addr;
            end
            if (clear || load_addr) begin
                lane  <= 2'd0;
                shift <= 24'd0;
            end else if (byte_valid) begin
                // Newest byte enters at the top, so byte 0 ends up in bits [7:0].
                shift <= {byte_in, shift[23:8]};
                lane  <= lane + 2'd1;
                if (lane == 2'd3) begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= {byte_in, shift};
                    addr    <= addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses SYNC/CMD/LEN/ADDR/payload[/CSUM] frames from the UART byte stream into memory writes.
// Macro UART_FRAME_CSUM_EN adds the trailing checksum byte and its check.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
    parameter int ADDR_W       = 16
) (
    input  logic              i_Clock,
    input  logic              i_Rst_L,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [31:0]       o_Wr_Data,
    output logic [7:0]        o_Cmd,
    output logic              o_Busy,
    output logic              o_Frame_Done,
    output logic [1:0]        o_Err_Code
);

    localparam int             TMO_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    // Strobe semantics: i_RX_DV qualifies i_RX_Byte for exactly one cycle and is
    // always accepted; o_Wr_En and o_Frame_Done are one-cycle strobes with no ready.
    frame_state_t     state;
    logic [7:0]       len_q;
    logic [7:0]       addr_hi_q;
    logic [9:0]       byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout;
    logic [15:0]      start_addr_full;

    assign o_Busy          = (state != IDLE);
    assign timeout         = o_Busy && !i_RX_DV && (tmo_cnt == TMO_LAST);
    assign start_addr_full = {addr_hi_q, i_RX_Byte};

`ifdef UART_FRAME_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            csum <= 8'd0;
        end else if (i_RX_DV) begin
            case (state)
                CMD:                              csum <= i_RX_Byte;
                LEN, ADDR_HI, ADDR_LO, PAYLOAD:   csum <= csum + i_RX_Byte;
                default:                          csum <= csum;
            endcase
        end
    end
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            len_q        <= 8'd0;
            addr_hi_q    <= 8'd0;
            byte_cnt     <= 10'd0;
            tmo_cnt      <= '0;
            o_Cmd        <= 8'd0;
            o_Frame_Done <= 1'b0;
            o_Err_Code   <= ERR_OK;
        end else begin
            o_Frame_Done <= 1'b0;
            tmo_cnt      <= (i_RX_DV || !o_Busy) ? '0 : tmo_cnt + TMO_W'(1);
            if (timeout) begin
                state        <= IDLE;
                o_Frame_Done <= 1'b1;
                o_Err_Code   <= ERR_TIMEOUT;
            end else if (i_RX_DV) begin
                case (state)
                    IDLE: if (i_RX_Byte == SYNC_BYTE) state <= CMD;
                    CMD: begin
                        o_Cmd <= i_RX_Byte;
                        state <= LEN;
                    end
                    LEN: begin
                        len_q <= i_RX_Byte;
                        state <= ADDR_HI;
                    end
                    ADDR_HI: begin
                        addr_hi_q <= i_RX_Byte;
                        state     <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        byte_cnt <= {len_q, 2'b00};
                        if (len_q != 8'd0) begin
                            state <= PAYLOAD;
                        end else begin
`ifdef UART_FRAME_CSUM_EN
                            state <= CSUM;
`else
                            state        <= IDLE;
                            o_Frame_Done <= 1'b1;
                            o_Err_Code   <= ERR_OK;
`endif
                        end
                    end
                    PAYLOAD: begin
                        byte_cnt <= byte_cnt - 10'd1;
                        if (byte_cnt == 10'd1) begin
`ifdef UART_FRAME_CSUM_EN
                            state <= CSUM;
`else
                            state        <= IDLE;
                            o_Frame_Done <= 1'b1;
                            o_Err_Code   <= ERR_OK;
`endif
                        end
                    end
`ifdef UART_FRAME_CSUM_EN
                    CSUM: begin
                        state        <= IDLE;
                        o_Frame_Done <= 1'b1;
                        o_Err_Code   <= (i_RX_Byte == csum) ? ERR_OK : ERR_CSUM;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    uart_word_packer #(
        .ADDR_W(ADDR_W)
    ) u_packer (
        .i_Clock    (i_Clock),
        .i_Rst_L    (i_Rst_L),
        .clear      (timeout),
        .load_addr  (i_RX_DV && state == ADDR_LO),
        .start_addr (start_addr_full[ADDR_W-1:0]),
        .byte_valid (i_RX_DV && state == PAYLOAD),
        .byte_in    (i_RX_Byte),
        .wr_en      (o_Wr_En),
        .wr_addr    (o_Wr_Addr),
        .wr_data    (o_Wr_Data)
    );

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed-sequence bench for uart_frame_loader with a write/completion scoreboard.
module tb_uart_frame_loader;
  import uart_frame_pkg::*;

  localparam int TO     = 40;
  localparam int ADDR_W = 16;

  logic              i_Clock   = 1'b0;
  logic              i_Rst_L   = 1'b0;
  logic              i_RX_DV   = 1'b0;
  logic [7:0]        i_RX_Byte = 8'd0;
  logic              o_Wr_En;
  logic [ADDR_W-1:0] o_Wr_Addr;
  logic [31:0]       o_Wr_Data;
  logic [7:0]        o_Cmd;
  logic              o_Busy;
  logic              o_Frame_Done;
  logic [1:0]        o_Err_Code;

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_q[$];
  logic [1:0]  exp_err_q[$];
  logic [7:0]  pl_q[$];

  // clock / reset block
  always #5 i_Clock = ~i_Clock;

  uart_frame_loader #(
    .CLKS_PER_BIT(2),
    .TIMEOUT_CLKS(TO),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Rst_L      (i_Rst_L),
    .i_RX_DV      (i_RX_DV),
    .i_RX_Byte    (i_RX_Byte),
    .o_Wr_En      (o_Wr_En),
    .o_Wr_Addr    (o_Wr_Addr),
    .o_Wr_Data    (o_Wr_Data),
    .o_Cmd        (o_Cmd),
    .o_Busy       (o_Busy),
    .o_Frame_Done (o_Frame_Done),
    .o_Err_Code   (o_Err_Code)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the next negedge
  task automatic send_byte(input logic [7:0] b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(negedge i_Clock);
    i_RX_DV   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [15:0] addr, input bit bad_cs, input int gap);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] word;
    logic [15:0] a;
    a    = addr;
    word = 32'd0;
`ifdef UART_FRAME_CSUM_EN
    exp_err_q.push_back(bad_cs ? ERR_CSUM : ERR_OK);
`else
    exp_err_q.push_back(ERR_OK);
`endif
    send_byte(SYNC_BYTE);
    idle(gap); send_byte(cmd);        sum = cmd;
    idle(gap); send_byte(len);        sum = sum + len;
    idle(gap); send_byte(addr[15:8]); sum = sum + addr[15:8];
    idle(gap); send_byte(addr[7:0]);  sum = sum + addr[7:0];
    for (int i = 0; i < int'(len) * 4; i++) begin
      b    = (pl_q.size() != 0) ? pl_q.pop_front() : 8'($urandom_range(0, 255));
      sum  = sum + b;
      word = {b, word[31:8]};
      if (i % 4 == 3) begin
        exp_q.push_back({a, word});
        a = a + 16'd1;
      end
      idle(gap);
      send_byte(b);
    end
`ifdef UART_FRAME_CSUM_EN
    idle(gap);
    send_byte(bad_cs ? sum + 8'd1 : sum);
`endif
  endtask

  // scoreboard: pop expectations as the DUT produces writes and completions
  always @(negedge i_Clock) begin
    if (i_Rst_L) begin
      if (o_Wr_En) begin
        chk("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("wr_addr_data", {o_Wr_Addr, o_Wr_Data}, exp_q.pop_front());
      end
      if (o_Frame_Done) begin
        chk("done_expected", exp_err_q.size() != 0, 1);
        if (exp_err_q.size() != 0) chk("done_err", o_Err_Code, exp_err_q.pop_front());
        chk("busy_at_done", o_Busy, 0);
      end
    end
  end

  initial begin
    idle(3);
    chk("rst_outputs", {o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Cmd, o_Busy, o_Frame_Done, o_Err_Code}, 0);
    i_Rst_L = 1'b1;
    idle(2);

    // noise before SYNC is ignored
    send_byte(8'h00); chk("noise_00", o_Busy, 0);
    send_byte(8'hFF); chk("noise_ff", o_Busy, 0);
    send_byte(8'h3C); chk("noise_3c", o_Busy, 0);

    // single word frame, known data
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(8'h10, 8'd1, 16'h0020, 1'b0, 0);
    idle(2);
    chk("cmd_a", o_Cmd, 8'h10);
    chk("err_a", o_Err_Code, ERR_OK);

`ifdef UART_FRAME_CSUM_EN
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(8'h10, 8'd1, 16'h0020, 1'b1, 0);
    idle(2);
    chk("err_csum_held", o_Err_Code, ERR_CSUM);
`endif

    // address wrap, then a back-to-back LEN=0 frame
    send_frame(8'h21, 8'd2, 16'hFFFF, 1'b0, 0);
    send_frame(8'h22, 8'd0, 16'h1234, 1'b0, 0);
    idle(2);
    chk("cmd_len0", o_Cmd, 8'h22);
    chk("err_len0", o_Err_Code, ERR_OK);

    // stall mid-word until timeout
    exp_err_q.push_back(ERR_TIMEOUT);
    send_byte(SYNC_BYTE); send_byte(8'h33); send_byte(8'h01);
    send_byte(8'h00);     send_byte(8'h40);
    send_byte(8'hDE);     send_byte(8'hAD);
    chk("busy_mid_frame", o_Busy, 1);
    idle(TO + 2);
    chk("busy_after_timeout", o_Busy, 0);
    chk("err_timeout", o_Err_Code, ERR_TIMEOUT);
    chk("no_partial_write", exp_q.size(), 0);
    send_frame(8'h44, 8'd3, 16'h0100, 1'b0, 0);
    idle(2);
    chk("err_after_timeout", o_Err_Code, ERR_OK);

    // every byte lands exactly on the timeout terminal cycle
    send_frame(8'h55, 8'd1, 16'h0080, 1'b0, TO - 1);
    idle(2);
    chk("err_terminal", o_Err_Code, ERR_OK);
    chk("cmd_terminal", o_Cmd, 8'h55);

    // reset mid-payload
    send_byte(SYNC_BYTE); send_byte(8'h66); send_byte(8'h02);
    send_byte(8'h00);     send_byte(8'h10);
    send_byte(8'h01);     send_byte(8'h02); send_byte(8'h03);
    i_Rst_L = 1'b0;
    #1;
    chk("rst_mid_outputs", {o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Cmd, o_Busy, o_Frame_Done, o_Err_Code}, 0);
    idle(2);
    i_Rst_L = 1'b1;
    idle(1);
    send_frame(8'h77, 8'd2, 16'h0008, 1'b0, 0);
    idle(2);
    chk("cmd_after_rst", o_Cmd, 8'h77);

    // random frames, back-to-back
    for (int i = 0; i < 4; i++) begin
      send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 4)),
                 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 0);
    end
    idle(5);

    chk("wr_q_drained", exp_q.size(), 0);
    chk("done_q_drained", exp_err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
